vending_return_controller: RTL

- Sequencing FSM for the vending-machine change-return path.
- Runs the inactivity wait timer while credit is held.
- On timeout or an explicit return request, dispenses the held credit as coins, one coin per cycle, largest denomination first.
- The datapath owns current_total and applies the requested subtraction; this block only decides what to return and when.

---
 rtl/vending_return_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vending_return_controller.sv
// Change-return sequencer: runs the inactivity timer while credit is held, then
// pays the held credit back one coin per cycle, largest denomination first.
module vending_return_controller #(
  parameter int TOTAL_BITS  = 31,
  parameter int NUM_COINS   = 3,
  parameter int COIN0_VALUE = 100,
  parameter int COIN1_VALUE = 500,
  parameter int COIN2_VALUE = 1000,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_activity,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] i_current_total,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic [TOTAL_BITS-1:0] o_sub_value,
  output logic                  o_busy,
  output logic [31:0]           o_wait_time,
  output logic                  o_return_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_CYCLES);

  logic [1:0]            r_state;
  logic [31:0]           r_timer;
  logic [1:0]            w_state_nxt;
  logic [31:0]           w_timer_nxt;
  logic [NUM_COINS-1:0]  w_coin;
  logic [TOTAL_BITS-1:0] w_sub;
  logic                  w_in_return;

  function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
    case (k)
      0:       coin_value = TOTAL_BITS'(COIN0_VALUE);
      1:       coin_value = TOTAL_BITS'(COIN1_VALUE);
      2:       coin_value = TOTAL_BITS'(COIN2_VALUE);
      default: coin_value = {TOTAL_BITS{1'b0}};
    endcase
  endfunction

  // Largest fitting coin; denominations ascend with index so the last hit wins.
  always_comb begin
    w_coin = {NUM_COINS{1'b0}};
    w_sub  = {TOTAL_BITS{1'b0}};
    for (int k = 0; k < NUM_COINS; k++) begin
      w_coin = ((coin_value(k) != '0) && (coin_value(k) <= i_current_total))
               ? (NUM_COINS'(1) << k) : w_coin;
      w_sub  = ((coin_value(k) != '0) && (coin_value(k) <= i_current_total))
               ? coin_value(k) : w_sub;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (i_activity) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = WAIT_RELOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = 32'd0;
        end
      end
      ST_WAIT: begin
        if (i_trigger_return) begin
          w_state_nxt = ST_RETURN;
          w_timer_nxt = 32'd0;
        end else if (i_current_total == '0) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = 32'd0;
        end else if (i_activity) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = WAIT_RELOAD;
        end else if (r_timer == 32'd1) begin
          w_state_nxt = ST_RETURN;
          w_timer_nxt = 32'd0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      ST_RETURN: begin
        w_timer_nxt = 32'd0;
        if (w_coin == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RETURN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 32'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 32'd0;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Coins are gated by reset so an interrupted return issues nothing in the reset cycle.
  assign w_in_return   = (r_state == ST_RETURN) && !reset;
  assign o_return_coin = w_in_return ? w_coin : {NUM_COINS{1'b0}};
  assign o_sub_value   = w_in_return ? w_sub : {TOTAL_BITS{1'b0}};
  assign o_busy        = (r_state == ST_RETURN) || (r_state == ST_DONE);
  assign o_return_done = (r_state == ST_DONE);
  assign o_wait_time   = r_timer;

endmodule
